darktimer_mc: RTL and testbench
===============================

Name: darktimer_mc

Overview:
Multi-channel timer/interrupt peripheral for the darksocv IO space. Generalises the SoC's single hard-wired timer, IREQ/IACK pair and microsecond counter into CHANNELS independent down-counters. Each channel has periodic or one-shot mode, a pending flag, an overrun flag and an IRQ enable. Sits on the darkriscv data bus behind the IO decode (DADDR[31]=1) and returns read data with one wait state, matching the existing DACK scheme.

Parameters:
CHANNELS, 4, number of timer channels (1..8)
BOARD_CK, 50000000, core clock in Hz
WIDTH, 32, counter and reload width in bits (8..32); upper bits read 0

Ports:
CLK  in  1  core clock
RES  in  1  synchronous active-high reset
WR  in  1  write strobe, qualified by caller with !HLT and IO decode
RD  in  1  read strobe, qualified by caller with !HLT and IO decode
ADDR  in  7  byte address within block; ADDR[1:0] ignored
BE  in  4  byte enables for writes
DATAI  in  32  write data
DATAO  out  32  read data, registered
IRQ  out  1  |(PEND & IRQEN)
IRQV  out  CHANNELS  per-channel PEND & IRQEN
USTICK  out  1  one-cycle pulse on each TIMEUS increment

Behaviour:
- Register map (word offsets):
  - 0x00 CTRL (RW): [7:0] EN, [15:8] ONESHOT, [23:16] IRQEN.
  - 0x04 STAT: [7:0] PEND, [15:8] OVR. Write-1-to-clear: a 1 in bit n clears PEND[n] and OVR[n]; a 1 in bit n+8 does the same.
  - 0x08 TIMEUS (RO).
  - 0x0C PRESCALE (RW).
  - 0x10+4n RELOAD[n] (RW).
  - 0x30+4n COUNT[n] (RO).
- Unmapped addresses and channels >= CHANNELS read 0; writes to them are ignored. CTRL bits of absent channels read 0.
- BE masks byte lanes on every RW register and on the STAT W1C.
- Reads: DATAO is registered from the address on the RD cycle and is valid on the next cycle. DATAO holds its value otherwise.
- Reset values:
  - DATAO, CTRL, STAT, TIMEUS, RELOAD[*], COUNT[*]: 0.
  - PRESCALE: BOARD_CK/1000000-1.
  - IRQ, IRQV, USTICK: 0.
- Prescaler:
  - Internal PCNT counts down from PRESCALE.
  - When PCNT==0: reload PCNT, TIMEUS+1 (wraps 2^32-1 to 0), USTICK=1 for that cycle.
  - PRESCALE==0 gives a tick every cycle.
  - Writing PRESCALE also loads PCNT.
- Channel n, per CLK, when EN[n]=1 and RELOAD[n]!=0:
  - COUNT!=0: COUNT-1.
  - COUNT==0: expiry. COUNT<=RELOAD, PEND[n]<=1, OVR[n]<=1 if PEND[n] was already 1. If ONESHOT[n], EN[n]<=0 and COUNT<=0 instead of reloading.
- Period is RELOAD+1 cycles.
- EN[n]=0 or RELOAD[n]==0: COUNT holds, no expiry.
- Writing RELOAD[n] loads COUNT[n] with the new value in the same cycle; that cycle's decrement/expiry is suppressed.
- Enabling a channel does not reload it; COUNT continues from its held value.
- Expiry and W1C on the same channel in the same cycle: set wins. PEND stays 1; OVR gets the normal expiry update.
- Software write to CTRL and one-shot auto-clear of EN in the same cycle: the auto-clear wins for that bit only.
- IRQ and IRQV are combinational from registered PEND/IRQEN, so they assert one cycle after expiry.
- RES mid-count returns all state to reset values on the next edge. No spurious PEND is produced.

Decomposition:
- Package darktimer_pkg: register offset constants, CTRL/STAT field positions, MAXCH=8.
- Sub-module darktimer_ch, instantiated CHANNELS times, owns:
  - COUNT/RELOAD state;
  - expiry detection;
  - one-shot clear request;
  - PEND/OVR set logic.
- Top owns the bus decode, CTRL/STAT/PRESCALE/TIMEUS registers and the read mux.

Test Plan:
- Reset then read each register -> 0, except PRESCALE = 49; IRQ=0; TIMEUS=1 after 50 cycles, USTICK pulses every 50 cycles.
- RELOAD[0]=9, CTRL=0x0001_0001 -> PEND[0] and IRQ rise every 10 cycles; W1C STAT=0x01 drops IRQ the next cycle.
- ONESHOT[1]=1, RELOAD[1]=4, EN[1]=1 -> single expiry after 5 cycles, EN[1] reads 0, COUNT[1]=0, no further PEND.
- RELOAD[2]=3 with PEND left uncleared for 2 periods -> OVR[2]=1; W1C with the expiry cycle aligned -> PEND[2] remains 1.
- CHANNELS=2: write RELOAD[5], read 0x24/0x44 -> 0; write BE=0001 to CTRL=0xFFFFFFFF -> CTRL reads 0x00000003.
- RES asserted mid-count with PEND set -> next cycle all STAT=0, IRQ=0, COUNT=0, PRESCALE=49.

Source files
------------

// File: rtl/darktimer_pkg.sv
// darktimer shared definitions: register word offsets, CTRL/STAT field
// positions and the byte-lane write merge used by every RW register.
package darktimer_pkg;

    localparam int MAXCH = 8;

    // Word offsets (ADDR[6:2])
    localparam logic [4:0] W_CTRL     = 5'd0;
    localparam logic [4:0] W_STAT     = 5'd1;
    localparam logic [4:0] W_TIMEUS   = 5'd2;
    localparam logic [4:0] W_PRESCALE = 5'd3;
    localparam logic [4:0] W_RELOAD   = 5'd4;   // 0x10 + 4n
    localparam logic [4:0] W_COUNT    = 5'd12;  // 0x30 + 4n

    // CTRL field LSBs
    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 8;
    localparam int CTRL_IRQEN   = 16;

    // STAT field LSBs
    localparam int STAT_PEND = 0;
    localparam int STAT_OVR  = 8;

    // Replace the byte lanes selected by be with wdata, keep the rest of old.
    function automatic logic [31:0] be_merge(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wdata[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/darktimer_ch.sv
// One down-counting timer channel: RELOAD/COUNT state, expiry detection,
// pending/overrun flags and the one-shot enable-clear request.
module darktimer_ch
    import darktimer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RES,
    input  logic             en,
    input  logic             oneshot,
    input  logic             clr,
    input  logic             reload_we,
    input  logic [3:0]       be,
    input  logic [31:0]      wdata,
    output logic [WIDTH-1:0] reload,
    output logic [WIDTH-1:0] count,
    output logic             pend,
    output logic             ovr,
    output logic             os_clr
);

    logic        expire;
    logic [31:0] wmerge;
    logic        unused_ok;

    assign wmerge    = be_merge(32'(reload), wdata, be);
    assign unused_ok = ^wmerge;

    // A RELOAD write takes the cycle, so it masks any expiry that would coincide.
    assign expire = en && (reload != '0) && (count == '0) && !reload_we;
    assign os_clr = expire && oneshot;

    // Counter, reload register and sticky flags; expiry beats a same-cycle clear.
    always_ff @(posedge CLK) begin
        if (RES) begin
            reload <= '0;
            count  <= '0;
            pend   <= 1'b0;
            ovr    <= 1'b0;
        end else begin
            if (reload_we) begin
                reload <= wmerge[WIDTH-1:0];
                count  <= wmerge[WIDTH-1:0];
            end else if (en && (reload != '0)) begin
                if (count != '0)  count <= count - WIDTH'(1);
                else if (oneshot) count <= '0;
                else              count <= reload;
            end

            if (expire)   pend <= 1'b1;
            else if (clr) pend <= 1'b0;

            if (expire && pend) ovr <= 1'b1;
            else if (clr)       ovr <= 1'b0;
        end
    end

endmodule

// File: rtl/darktimer_mc.sv
// Multi-channel timer/interrupt block for the darksocv IO space: bus decode,
// CTRL/STAT/PRESCALE/TIMEUS registers, microsecond prescaler and read mux.
module darktimer_mc
    import darktimer_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int BOARD_CK = 50000000,
    parameter int WIDTH    = 32
) (
    input  logic                CLK,
    input  logic                RES,
    input  logic                WR,
    input  logic                RD,
    input  logic [6:0]          ADDR,
    input  logic [3:0]          BE,
    input  logic [31:0]         DATAI,
    output logic [31:0]         DATAO,
    output logic                IRQ,
    output logic [CHANNELS-1:0] IRQV,
    output logic                USTICK
);

    localparam logic [31:0] PRESCALE_RST = 32'(BOARD_CK / 1000000 - 1);

    logic [4:0]          word;
    logic [CHANNELS-1:0] en, oneshot, irqen, pend, ovr, os_clr, reload_we, stat_clr;
    logic [31:0]         prescale, pcnt, timeus;
    logic [31:0]         ctrl_word, ctrl_wr, prescale_wr, rdata;
    logic [7:0]          stat_mask;
    logic                ctrl_we, stat_we, pre_we;
    logic [WIDTH-1:0]    ch_reload [CHANNELS];
    logic [WIDTH-1:0]    ch_count  [CHANNELS];
    logic                unused_ok;

    assign word    = ADDR[6:2];
    assign ctrl_we = WR && (word == W_CTRL);
    assign stat_we = WR && (word == W_STAT);
    assign pre_we  = WR && (word == W_PRESCALE);

    assign ctrl_word   = {8'd0, 8'(irqen), 8'(oneshot), 8'(en)};
    assign ctrl_wr     = be_merge(ctrl_word, DATAI, BE);
    assign prescale_wr = be_merge(prescale, DATAI, BE);

    // Either STAT byte clears the channel: bit n or bit n+8.
    assign stat_mask = (DATAI[STAT_PEND +: 8] & {8{BE[0]}}) |
                       (DATAI[STAT_OVR  +: 8] & {8{BE[1]}});
    assign stat_clr  = stat_we ? stat_mask[CHANNELS-1:0] : '0;

    assign IRQV   = pend & irqen;
    assign IRQ    = |IRQV;
    assign USTICK = (pcnt == 32'd0);

    assign unused_ok = ^{ADDR[1:0], ctrl_wr, stat_mask};

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        assign reload_we[n] = WR && (word == W_RELOAD + 5'(n));

        darktimer_ch #(.WIDTH(WIDTH)) u_ch (
            .CLK       (CLK),
            .RES       (RES),
            .en        (en[n]),
            .oneshot   (oneshot[n]),
            .clr       (stat_clr[n]),
            .reload_we (reload_we[n]),
            .be        (BE),
            .wdata     (DATAI),
            .reload    (ch_reload[n]),
            .count     (ch_count[n]),
            .pend      (pend[n]),
            .ovr       (ovr[n]),
            .os_clr    (os_clr[n])
        );
    end

    // CTRL register; a one-shot expiry clears its EN bit even over a software write.
    always_ff @(posedge CLK) begin
        if (RES) begin
            en      <= '0;
            oneshot <= '0;
            irqen   <= '0;
        end else if (ctrl_we) begin
            en      <= ctrl_wr[CTRL_EN      +: CHANNELS] & ~os_clr;
            oneshot <= ctrl_wr[CTRL_ONESHOT +: CHANNELS];
            irqen   <= ctrl_wr[CTRL_IRQEN   +: CHANNELS];
        end else begin
            en      <= en & ~os_clr;
        end
    end

    // Microsecond prescaler and free-running TIMEUS; a PRESCALE write restarts the count.
    always_ff @(posedge CLK) begin
        if (RES) begin
            prescale <= PRESCALE_RST;
            pcnt     <= PRESCALE_RST;
            timeus   <= 32'd0;
        end else begin
            if (pcnt == 32'd0) timeus <= timeus + 32'd1;

            if (pre_we) begin
                prescale <= prescale_wr;
                pcnt     <= prescale_wr;
            end else if (pcnt == 32'd0) begin
                pcnt     <= prescale;
            end else begin
                pcnt     <= pcnt - 32'd1;
            end
        end
    end

    // Read mux; absent channels and unmapped words fall through to zero.
    always_comb begin
        rdata = 32'd0;
        case (word)
            W_CTRL:     rdata = ctrl_word;
            W_STAT:     rdata = {16'd0, 8'(ovr), 8'(pend)};
            W_TIMEUS:   rdata = timeus;
            W_PRESCALE: rdata = prescale;
            default:    rdata = 32'd0;
        endcase
        for (int n = 0; n < CHANNELS; n++) begin
            if (word == W_RELOAD + 5'(n)) rdata = 32'(ch_reload[n]);
            if (word == W_COUNT  + 5'(n)) rdata = 32'(ch_count[n]);
        end
    end

    // Registered read data, one wait state; held between reads.
    always_ff @(posedge CLK) begin
        if (RES)     DATAO <= 32'd0;
        else if (RD) DATAO <= rdata;
    end

endmodule

// File: tb/tb_darktimer_mc.sv
// Scoreboard bench for darktimer_mc: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever the DUT presents an output.
module tb_darktimer_mc;

    localparam int KD1 = 0, KD2 = 1, KIRQ = 2, KIRQV = 3, KUS = 4;

    typedef struct {
        int          kind;
        string       name;
        logic [31:0] exp;
    } chk_t;

    chk_t sb[$];

    logic        CLK = 1'b0;
    logic        RES = 1'b1;
    logic        WR = 1'b0, RD = 1'b0;
    logic [6:0]  ADDR = '0;
    logic [3:0]  BE = '0;
    logic [31:0] DATAI = '0;
    logic [31:0] DATAO, DATAO2;
    logic        IRQ, IRQ2, USTICK, USTICK2;
    logic [3:0]  IRQV;
    logic [1:0]  IRQV2;
    logic        rd_q = 1'b0;
    logic        prb = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 CLK = ~CLK;

    darktimer_mc #(.CHANNELS(4), .BOARD_CK(50000000), .WIDTH(32)) u_dut (
        .CLK(CLK), .RES(RES), .WR(WR), .RD(RD), .ADDR(ADDR), .BE(BE), .DATAI(DATAI),
        .DATAO(DATAO), .IRQ(IRQ), .IRQV(IRQV), .USTICK(USTICK)
    );

    darktimer_mc #(.CHANNELS(2), .BOARD_CK(50000000), .WIDTH(16)) u_dut2 (
        .CLK(CLK), .RES(RES), .WR(WR), .RD(RD), .ADDR(ADDR), .BE(BE), .DATAI(DATAI),
        .DATAO(DATAO2), .IRQ(IRQ2), .IRQV(IRQV2), .USTICK(USTICK2)
    );

    // Read data becomes valid the cycle after RD is sampled.
    always @(posedge CLK) rd_q <= RD;

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            KD1:     return DATAO;
            KD2:     return DATAO2;
            KIRQ:    return 32'(IRQ);
            KIRQV:   return 32'(IRQV);
            default: return 32'(USTICK);
        endcase
    endfunction

    task automatic pop_check();
        chk_t        c;
        logic [31:0] a;
        n_checks++;
        if (sb.size() == 0) begin
            $display("FAIL unexpected_output: scoreboard empty at %0t", $time);
            return;
        end
        c = sb.pop_front();
        a = actual(c.kind);
        if (a === c.exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", c.name, a, c.exp);
    endtask

    // Monitor: read responses first, then same-cycle output probes.
    always @(negedge CLK) begin
        if (rd_q) pop_check();
        if (prb)  pop_check();
    end

    task automatic push(input int kind, input logic [31:0] e, input string nm);
        chk_t c;
        c.kind = kind;
        c.name = nm;
        c.exp  = e;
        sb.push_back(c);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d, input logic [3:0] be);
        WR = 1'b1; ADDR = a; DATAI = d; BE = be;
        step();
        WR = 1'b0; BE = 4'h0;
    endtask

    task automatic rd(input int kind, input logic [6:0] a, input logic [31:0] e, input string nm);
        push(kind, e, nm);
        RD = 1'b1; ADDR = a;
        step();
        RD = 1'b0;
    endtask

    task automatic probe(input int kind, input logic [31:0] e, input string nm);
        push(kind, e, nm);
        prb = 1'b1;
        step();
        prb = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        RES = 1'b0;

        // Reset state
        probe(KIRQ,  32'd0, "rst_irq");
        probe(KIRQV, 32'd0, "rst_irqv");
        rd(KD1, 7'h00, 32'd0,  "rst_ctrl");
        rd(KD1, 7'h04, 32'd0,  "rst_stat");
        rd(KD1, 7'h08, 32'd0,  "rst_timeus");
        rd(KD1, 7'h0C, 32'd49, "rst_prescale");
        rd(KD1, 7'h10, 32'd0,  "rst_reload0");
        rd(KD1, 7'h30, 32'd0,  "rst_count0");
        rd(KD1, 7'h1C, 32'd0,  "rst_reload3");
        rd(KD1, 7'h3C, 32'd0,  "rst_count3");
        rd(KD1, 7'h50, 32'd0,  "unmapped_50");
        rd(KD1, 7'h7C, 32'd0,  "unmapped_7c");

        // Microsecond tick every 50 cycles
        probe(KUS, 32'd0, "ustick_low");
        idle(36);
        probe(KUS, 32'd1, "ustick_first");
        rd(KD1, 7'h08, 32'd1, "timeus_1");
        probe(KUS, 32'd0, "ustick_after");
        idle(47);
        probe(KUS, 32'd1, "ustick_second");
        rd(KD1, 7'h08, 32'd2, "timeus_2");

        // Periodic channel 0, period 10, with IRQ
        wr(7'h10, 32'd9, 4'hF);
        wr(7'h00, 32'h0001_0001, 4'hF);
        idle(9);
        probe(KIRQ,  32'd0, "ch0_irq_before");
        probe(KIRQ,  32'd1, "ch0_irq_rise");
        probe(KIRQV, 32'd1, "ch0_irqv");
        rd(KD1, 7'h04, 32'h0000_0001, "ch0_stat_pend");
        rd(KD1, 7'h30, 32'd6, "ch0_count");
        wr(7'h04, 32'h0000_0001, 4'hF);
        probe(KIRQ, 32'd0, "ch0_irq_cleared");
        idle(3);
        probe(KIRQ, 32'd0, "ch0_irq_pre2");
        probe(KIRQ, 32'd1, "ch0_irq_rise2");
        wr(7'h04, 32'h0000_0001, 4'hF);
        wr(7'h00, 32'h0000_0000, 4'hF);
        rd(KD1, 7'h04, 32'd0, "ch0_stat_clear");

        // One-shot channel 1
        wr(7'h14, 32'd4, 4'hF);
        wr(7'h00, 32'h0000_0202, 4'hF);
        idle(4);
        rd(KD1, 7'h00, 32'h0000_0202, "os_ctrl_before");
        rd(KD1, 7'h04, 32'h0000_0002, "os_stat_pend");
        rd(KD1, 7'h00, 32'h0000_0200, "os_en_cleared");
        rd(KD1, 7'h34, 32'd0, "os_count_zero");
        idle(10);
        rd(KD1, 7'h04, 32'h0000_0002, "os_no_overrun");
        wr(7'h04, 32'h0000_0200, 4'h2);
        rd(KD1, 7'h04, 32'd0, "os_w1c_hi_byte");

        // Overrun on channel 2 and expiry-vs-W1C collision
        wr(7'h18, 32'd3, 4'hF);
        wr(7'h00, 32'h0000_0004, 4'hF);
        idle(8);
        rd(KD1, 7'h04, 32'h0000_0404, "ovr_set");
        idle(2);
        wr(7'h04, 32'h0000_0004, 4'hF);
        rd(KD1, 7'h04, 32'h0000_0404, "ovr_set_wins");
        wr(7'h04, 32'h0000_0004, 4'hF);
        rd(KD1, 7'h04, 32'd0, "ovr_cleared");
        rd(KD1, 7'h04, 32'd0, "ovr_cleared_hold");
        rd(KD1, 7'h04, 32'h0000_0004, "ovr_repend");

        // Reset mid-count with PEND set
        wr(7'h00, 32'h0004_0004, 4'hF);
        probe(KIRQ,  32'd1, "pre_res_irq");
        probe(KIRQV, 32'h4, "pre_res_irqv");
        wr(7'h0C, 32'd7, 4'hF);
        rd(KD1, 7'h0C, 32'd7, "prescale_written");
        RES = 1'b1;
        step();
        RES = 1'b0;
        probe(KIRQ,  32'd0, "res_irq");
        probe(KIRQV, 32'd0, "res_irqv");
        probe(KUS,   32'd0, "res_ustick");
        rd(KD1, 7'h04, 32'd0,  "res_stat");
        rd(KD1, 7'h38, 32'd0,  "res_count2");
        rd(KD1, 7'h18, 32'd0,  "res_reload2");
        rd(KD1, 7'h00, 32'd0,  "res_ctrl");
        rd(KD1, 7'h08, 32'd0,  "res_timeus");
        rd(KD1, 7'h0C, 32'd49, "res_prescale");
        probe(KD1, 32'd49, "datao_hold");

        // Absent channels, byte lanes and narrow WIDTH
        wr(7'h24, 32'h0000_1234, 4'hF);
        rd(KD2, 7'h24, 32'd0, "ch2_reload5");
        rd(KD2, 7'h44, 32'd0, "ch2_count5");
        rd(KD1, 7'h24, 32'd0, "ch4_reload5");
        wr(7'h00, 32'hFFFF_FFFF, 4'h1);
        rd(KD2, 7'h00, 32'h0000_0003, "ch2_ctrl_be0");
        rd(KD1, 7'h00, 32'h0000_000F, "ch4_ctrl_be0");
        wr(7'h00, 32'h0000_0F00, 4'h2);
        rd(KD1, 7'h00, 32'h0000_0F0F, "ch4_ctrl_be1");
        rd(KD2, 7'h00, 32'h0000_0303, "ch2_ctrl_be1");
        wr(7'h10, 32'hFFFF_ABCD, 4'hF);
        rd(KD2, 7'h10, 32'h0000_ABCD, "w16_reload0");
        rd(KD1, 7'h10, 32'hFFFF_ABCD, "w32_reload0");

        step();
        step();
        while (sb.size() != 0) begin
            chk_t c;
            c = sb.pop_front();
            n_checks++;
            $display("FAIL %s: no response, required 0x%08h", c.name, c.exp);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
